// File: rtl/md_sched.sv
// md_sched: launch, fixed-latency tracking, HI/LO commit and D-stage hazard stall
// for the shared multiply/divide unit of the 5-stage pipeline.

module md_sched_chk (
  input logic       clk,
  input logic       reset,
  input logic       start,
  input logic       busy,
  input logic       hilo_we,
  input logic       hi_we,
  input logic       lo_we,
  input logic [2:0] op_q,
  input logic [3:0] cnt
);
  a_op_q_range : assert property (@(posedge clk) disable iff (reset) (op_q <= 3'd4));
  a_busy_op    : assert property (@(posedge clk) disable iff (reset) (busy == (op_q != 3'd0)));
  a_idle_cnt   : assert property (@(posedge clk) disable iff (reset) (!busy |-> (cnt == 4'd0)));
  a_busy_cnt   : assert property (@(posedge clk) disable iff (reset) (busy |-> (cnt != 4'd0)));
  a_no_restart : assert property (@(posedge clk) disable iff (reset) (!(start && busy)));
  a_commit     : assert property (@(posedge clk) disable iff (reset) (hilo_we |-> !busy));
  a_mt_onehot  : assert property (@(posedge clk) disable iff (reset) (!(hi_we && lo_we)));
endmodule

module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] md_op_e,
  input  logic       md_use_d,
  input  logic       IntReq,
  output logic       start,
  output logic       busy,
  output logic       stall_md,
  output logic       hilo_we,
  output logic       hi_we,
  output logic       lo_we,
  output logic [2:0] op_q,
  output logic [3:0] cnt,
  output logic       err
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  state_t state_r;
  logic   op_arith_s;
  logic   op_mt_s;
  logic   launch_s;
  logic   violation_s;

  function automatic logic [3:0] op_latency(input logic [3:0] op);
    case (op)
      4'd1, 4'd2: op_latency = MULT_LAT;
      4'd3, 4'd4: op_latency = DIV_LAT;
      default:    op_latency = 4'd0;
    endcase
  endfunction

  // Decode the E-stage op into same-cycle launch, mthi/mtlo write and stall strobes.
  always_comb begin
    op_arith_s = 1'b0;
    op_mt_s    = 1'b0;
    case (md_op_e)
      4'd1, 4'd2, 4'd3, 4'd4: op_arith_s = 1'b1;
      4'd5, 4'd6:             op_mt_s    = 1'b1;
      default: begin
        op_arith_s = 1'b0;
        op_mt_s    = 1'b0;
      end
    endcase
    launch_s    = (state_r == IDLE) && op_arith_s && !IntReq;
    violation_s = busy && (op_arith_s || op_mt_s) && !IntReq;
    start       = launch_s;
    hi_we       = (md_op_e == 4'd5) && !IntReq && !busy;
    lo_we       = (md_op_e == 4'd6) && !IntReq && !busy;
    // The commit cycle is deliberately not stalled: mfhi/mflo see the result via bypass.
    stall_md    = md_use_d && (launch_s || busy);
  end

  // Occupancy FSM: latch the op and its latency on launch, count down, pulse the commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      hilo_we <= 1'b0;
      op_q    <= 3'd0;
      cnt     <= 4'd0;
      err     <= 1'b0;
    end else begin
      hilo_we <= 1'b0;
      if (violation_s) begin
        err <= 1'b1;
      end else begin
        err <= err;
      end
      case (state_r)
        IDLE: begin
          if (launch_s) begin
            state_r <= RUN;
            busy    <= 1'b1;
            op_q    <= md_op_e[2:0];
            cnt     <= op_latency(md_op_e);
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
            op_q    <= 3'd0;
            cnt     <= 4'd0;
          end
        end
        RUN: begin
          // cnt<=1 also covers a corrupted zero count so it can never wrap.
          if (cnt <= 4'd1) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            op_q    <= 3'd0;
            cnt     <= 4'd0;
            hilo_we <= 1'b1;
          end else begin
            state_r <= RUN;
            cnt     <= cnt - 4'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          op_q    <= 3'd0;
          cnt     <= 4'd0;
        end
      endcase
    end
  end

  md_sched_chk u_chk (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .busy    (busy),
    .hilo_we (hilo_we),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .op_q    (op_q),
    .cnt     (cnt)
  );

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed scenarios plus random traffic, each
// cycle compared against a launch-timestamp model of the unit's occupancy.

module tb_md_sched;
  localparam int MC = 5;
  localparam int DC = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] md_op_e;
  logic       md_use_d;
  logic       IntReq;
  logic       start, busy, stall_md, hilo_we, hi_we, lo_we, err;
  logic [2:0] op_q;
  logic [3:0] cnt;

  md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .md_op_e(md_op_e), .md_use_d(md_use_d), .IntReq(IntReq),
    .start(start), .busy(busy), .stall_md(stall_md), .hilo_we(hilo_we),
    .hi_we(hi_we), .lo_we(lo_we), .op_q(op_q), .cnt(cnt), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: an operation launched in cycle L with latency N is busy in cycles L+1..L+N
  // and commits in cycle L+N+1; the sticky error flag is tracked separately.
  int  cyc = 0;
  bit  run_active = 1'b0;
  int  launch_cyc = 0;
  int  run_len = 0;
  int  run_op = 0;
  bit  m_err = 1'b0;
  int  cur_op;
  bit  cur_irq, cur_rst;
  bit  e_start, e_busy, e_stall, e_hilo, e_hi, e_lo;
  int  e_opq, e_cnt;
  logic [13:0] exp_vec;
  wire  [13:0] act_vec = {start, busy, stall_md, hilo_we, hi_we, lo_we, op_q, cnt, err};

  task automatic cycle_begin(input int op, input bit use_d, input bit irq, input bit rst);
    reset = rst; md_op_e = 4'(op); md_use_d = use_d; IntReq = irq;
    cur_op = op; cur_irq = irq; cur_rst = rst;
    @(negedge clk);
    e_busy  = run_active && (cyc > launch_cyc) && (cyc <= launch_cyc + run_len);
    e_hilo  = run_active && (cyc == launch_cyc + run_len + 1);
    e_cnt   = e_busy ? (launch_cyc + run_len + 1 - cyc) : 0;
    e_opq   = e_busy ? run_op : 0;
    e_start = !e_busy && (op >= 1) && (op <= 4) && !irq;
    e_hi    = (op == 5) && !irq && !e_busy;
    e_lo    = (op == 6) && !irq && !e_busy;
    e_stall = use_d && (e_start || e_busy);
    exp_vec = {e_start, e_busy, e_stall, e_hilo, e_hi, e_lo, 3'(e_opq), 4'(e_cnt), m_err};
  endtask

  task automatic cycle_end();
    if (cur_rst) begin
      run_active = 1'b0;
      m_err      = 1'b0;
    end else begin
      if (e_busy && (cur_op >= 1) && (cur_op <= 6) && !cur_irq) m_err = 1'b1;
      if (e_start) begin
        run_active = 1'b1;
        launch_cyc = cyc;
        run_len    = (cur_op <= 2) ? MC : DC;
        run_op     = cur_op;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle_begin(0, 0, 0, 1);
    cycle_end();
    for (int i = 0; i < 2; i++) begin
      cycle_begin(0, 0, 0, 0);
      n_checks++;
      if ({busy, hilo_we, op_q, cnt, err} !== {1'b0, 1'b0, 3'd0, 4'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_state i=%0d got %b expected all zero", i, {busy, hilo_we, op_q, cnt, err});
      end
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_vec i=%0d got %b expected %b", i, act_vec, exp_vec);
      end
      cycle_end();
    end
  endtask

  task automatic test_mult();
    for (int i = 0; i < 8; i++) begin
      cycle_begin((i == 0) ? 1 : 0, 0, 0, 0);
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL mult_vec i=%0d got %b expected %b", i, act_vec, exp_vec);
      end
      if (i == 0) begin
        n_checks++;
        if (start !== 1'b1) begin n_fail++; $display("FAIL mult_start got %b expected 1", start); end
      end
      if (i >= 1 && i <= 5) begin
        n_checks++;
        if ({busy, op_q, cnt} !== {1'b1, 3'd1, 4'(6 - i)}) begin
          n_fail++;
          $display("FAIL mult_busy i=%0d got %b expected %b", i, {busy, op_q, cnt}, {1'b1, 3'd1, 4'(6 - i)});
        end
      end
      if (i >= 6) begin
        n_checks++;
        if ({busy, op_q, hilo_we} !== {1'b0, 3'd0, (i == 6) ? 1'b1 : 1'b0}) begin
          n_fail++;
          $display("FAIL mult_commit i=%0d got %b expected hilo_we=%0d idle", i, {busy, op_q, hilo_we}, (i == 6));
        end
      end
      cycle_end();
    end
  endtask

  task automatic test_div_stall();
    int stalls = 0;
    for (int i = 0; i < 13; i++) begin
      cycle_begin((i == 0) ? 3 : 0, 1, 0, 0);
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL div_vec i=%0d got %b expected %b", i, act_vec, exp_vec);
      end
      if (stall_md === 1'b1) stalls++;
      n_checks++;
      if ({stall_md, hilo_we} !== {(i <= 10) ? 1'b1 : 1'b0, (i == 11) ? 1'b1 : 1'b0}) begin
        n_fail++;
        $display("FAIL div_stall i=%0d got stall=%b hilo_we=%b", i, stall_md, hilo_we);
      end
      if (i == 1) begin
        n_checks++;
        if (cnt !== 4'd10) begin n_fail++; $display("FAIL div_cnt0 got %0d expected 10", cnt); end
      end
      cycle_end();
    end
    n_checks++;
    if (stalls != 11) begin n_fail++; $display("FAIL div_stall_count got %0d expected 11", stalls); end
  endtask

  task automatic test_intreq_cancel();
    for (int i = 0; i < 8; i++) begin
      cycle_begin((i == 0) ? 2 : ((i == 1) ? 5 : 0), 0, (i == 0), 0);
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL cancel_vec i=%0d got %b expected %b", i, act_vec, exp_vec);
      end
      n_checks++;
      if ({start, busy, hilo_we, hi_we} !== {1'b0, 1'b0, 1'b0, (i == 1) ? 1'b1 : 1'b0}) begin
        n_fail++;
        $display("FAIL cancel i=%0d got start/busy/hilo/hi %b expected hi_we=%0d only", i,
                 {start, busy, hilo_we, hi_we}, (i == 1));
      end
      cycle_end();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      cycle_begin((i == 0) ? 3 : ((i == 11) ? 4 : 0), 0, (i == 4), 0);
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL b2b_vec i=%0d got %b expected %b", i, act_vec, exp_vec);
      end
      if (i >= 1 && i <= 10) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy i=%0d got %b expected 1", i, busy); end
      end
      if (i == 11) begin
        n_checks++;
        if ({start, hilo_we} !== 2'b11) begin
          n_fail++;
          $display("FAIL b2b_overlap got start/hilo_we %b expected 11", {start, hilo_we});
        end
      end
      if (i == 12) begin
        n_checks++;
        if ({busy, op_q, cnt} !== {1'b1, 3'd4, 4'd10}) begin
          n_fail++;
          $display("FAIL b2b_relaunch got %b expected %b", {busy, op_q, cnt}, {1'b1, 3'd4, 4'd10});
        end
      end
      cycle_end();
    end
  endtask

  task automatic test_violation();
    for (int i = 0; i < 11; i++) begin
      cycle_begin((i == 0) ? 1 : ((i == 2) ? 6 : 0), 0, 0, (i == 9));
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL viol_vec i=%0d got %b expected %b", i, act_vec, exp_vec);
      end
      if (i == 2) begin
        n_checks++;
        if ({lo_we, start, err} !== 3'b000) begin
          n_fail++;
          $display("FAIL viol_ignored got lo_we/start/err %b expected 000", {lo_we, start, err});
        end
      end
      if (i >= 3) begin
        n_checks++;
        if (err !== ((i <= 9) ? 1'b1 : 1'b0)) begin
          n_fail++;
          $display("FAIL viol_err i=%0d got %b expected %0d", i, err, (i <= 9));
        end
      end
      cycle_end();
    end
  endtask

  task automatic test_reset_during_run();
    for (int i = 0; i < 16; i++) begin
      cycle_begin((i == 0) ? 4 : 0, 0, 0, (i == 3));
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL rstrun_vec i=%0d got %b expected %b", i, act_vec, exp_vec);
      end
      if (i >= 4) begin
        n_checks++;
        if ({busy, cnt, op_q, hilo_we} !== {1'b0, 4'd0, 3'd0, 1'b0}) begin
          n_fail++;
          $display("FAIL rstrun i=%0d got %b expected all zero", i, {busy, cnt, op_q, hilo_we});
        end
      end
      cycle_end();
    end
  endtask

  task automatic test_random();
    int r;
    int op;
    for (int i = 0; i < 1500; i++) begin
      r  = int'($urandom_range(0, 21));
      op = (r < 16) ? r : 0;
      cycle_begin(op, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL random_vec i=%0d op=%0d got %b expected %b", i, op, act_vec, exp_vec);
      end
      cycle_end();
    end
  endtask

  initial begin
    reset = 1'b1; md_op_e = 4'd0; md_use_d = 1'b0; IntReq = 1'b0;
    #1;
    test_reset();
    test_mult();
    test_div_stall();
    test_intreq_cancel();
    test_back_to_back();
    test_violation();
    test_reset_during_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
